clk_div_ctrl: RTL

Sequencer that reconfigures the programmable clock divider ratio without glitches or truncated output periods. It accepts new divide ratios over a valid/ready handshake and tracks the divider's phase with a mirror counter. It drives the divider's `divider` input only at a period boundary, then reports settling. It sits between the register/wrapper logic and the clock divider, and is clocked by the divider's input clock.

---
 rtl/clk_div_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//
// Purpose:
//   Glitch-free reconfiguration sequencer for a programmable clock divider.
//   New ratios arrive over a valid/ready handshake. A mirror counter tracks
//   the divider's phase, so the divider's ratio input only changes on the
//   same edge that starts a new divider period.
//
// Optional feature (compile-time macro CLK_DIV_CTRL_SETTLE_EN):
//   When defined, a SETTLE state holds 'locked' low for SETTLE_CYC cycles
//   after every ratio change. When undefined, WAIT returns straight to IDLE.
//
// Parameters:
//   N            width of the divide ratio (must match the divider)
//   DEFAULT_DIV  ratio driven after reset, non-zero
//   SETTLE_CYC   settle hold in clk_in cycles, 1..255 (settle build only)
//
// Ports:
//   clk_in     in   divider input clock, the only clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   new ratio request
//   req_div    in   requested ratio (N bits)
//   req_ready  out  high only in IDLE
//   div_out    out  registered ratio for the divider's 'divider' port
//   locked     out  div_out is stable and settled
//   busy       out  a ratio change is in progress
//   err        out  sticky, set by a zero-ratio request
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int N           = 4,
  parameter int DEFAULT_DIV = 1,
  parameter int SETTLE_CYC  = 8
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic [N-1:0] req_div,
  output logic         req_ready,
  output logic [N-1:0] div_out,
  output logic         locked,
  output logic         busy,
  output logic         err
);

`ifdef CLK_DIV_CTRL_SETTLE_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SETTLE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1
  } state_t;
`endif

  // Reject parameter values that would break the phase arithmetic.
  if (DEFAULT_DIV < 1 || DEFAULT_DIV >= (2 ** N)) begin : g_bad_default_div
    $error("clk_div_ctrl: DEFAULT_DIV must be in 1..2**N-1");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle_cyc
    $error("clk_div_ctrl: SETTLE_CYC must be in 1..255");
  end

  state_t       state_q, state_d;
  logic [N-1:0] div_q, div_d;
  logic [N-1:0] phase_q, phase_d;
  logic [N-1:0] pending_q, pending_d;
  logic         err_q, err_d;
  logic [N-1:0] divMinus1;
  logic         boundary;

`ifdef CLK_DIV_CTRL_SETTLE_EN
  logic [7:0]   settle_q, settle_d;
`endif

  // Mirror of the divider's own counter. div_q is never zero, so the N-bit
  // subtraction cannot underflow. On the apply edge the boundary condition
  // already forces phase to zero, so no separate clear is needed there.
  assign divMinus1 = div_q - N'(1);
  assign boundary  = (phase_q >= divMinus1);
  assign phase_d   = boundary ? '0 : phase_q + N'(1);

  // Next-state logic: accept in IDLE, apply on a period boundary in WAIT.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pending_d = pending_q;
    err_d     = err_q;
`ifdef CLK_DIV_CTRL_SETTLE_EN
    settle_d  = settle_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_div == '0) begin
            err_d = 1'b1;
          end else if (req_div == div_q) begin
            err_d = 1'b0;
          end else begin
            pending_d = req_div;
            err_d     = 1'b0;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (boundary) begin
          div_d = pending_q;
`ifdef CLK_DIV_CTRL_SETTLE_EN
          settle_d = 8'(SETTLE_CYC - 1);
          state_d  = SETTLE;
`else
          state_d  = IDLE;
`endif
        end
      end
`ifdef CLK_DIV_CTRL_SETTLE_EN
      SETTLE: begin
        // Loaded with SETTLE_CYC-1, so IDLE is reached SETTLE_CYC edges
        // after the apply edge.
        if (settle_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any pending request.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= N'(DEFAULT_DIV);
      phase_q   <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

`ifdef CLK_DIV_CTRL_SETTLE_EN
  // Settle down-counter, only meaningful while in SETTLE.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= 8'd0;
    end else begin
      settle_q <= settle_d;
    end
  end
`endif

  assign req_ready = (state_q == IDLE);
  assign locked    = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign div_out   = div_q;
  assign err       = err_q;

endmodule
